// File: rtl/div32_seq_pkg.sv
// Shared definitions for the sequential 32-bit divider: FSM encoding and step-counter sizing.
package div32_seq_pkg;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_DONE = 2'd2
   } div_state_t;

   localparam int DIV_STEPS = 32;
   localparam int DIV_CNT_W = 5;

endpackage

// File: rtl/div32_seq_step.sv
// One restoring shift-and-subtract step: retires a single quotient bit.
module div32_seq_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             dvd_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // The partial remainder stays below the divisor, so the kept value always fits in WIDTH bits.
   assign shifted  = {rem, dvd_bit};
   assign diff     = shifted + ~{1'b0, divisor} + {{WIDTH{1'b0}}, 1'b1};
   assign q_bit    = ~diff[WIDTH];
   assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div32_seq.sv
// Iterative signed/unsigned divider with start/done handshake; one quotient bit per cycle.
// state    | meaning
// DIV_IDLE | waiting for start_i, results held
// DIV_CALC | performing the 32 shift-and-subtract steps
// DIV_DONE | results valid, done_o pulse; start_i may launch the next division
module div32_seq
   import div32_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             signed_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             div_by_zero_o
);

   div_state_t             state_q, state_d;
   logic [DIV_CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]       rem_q;
   logic [WIDTH-1:0]       quo_q;
   logic [WIDTH-1:0]       dvsr_q;
   logic                   quo_neg_q;
   logic                   rem_neg_q;

   logic                   accept;
   logic                   div_zero;
   logic                   last_step;
   logic                   dvd_neg;
   logic                   dvs_neg;
   logic [WIDTH-1:0]       dvd_mag;
   logic [WIDTH-1:0]       dvs_mag;
   logic [WIDTH-1:0]       rem_next;
   logic                   q_bit;
   logic [WIDTH-1:0]       quo_next;

   assign accept    = start_i && (state_q == DIV_IDLE || state_q == DIV_DONE);
   assign div_zero  = (divisor_i == '0);
   assign last_step = (cnt_q == DIV_CNT_W'(DIV_STEPS - 1));
   assign dvd_neg   = signed_i && dividend_i[WIDTH-1];
   assign dvs_neg   = signed_i && divisor_i[WIDTH-1];
   assign dvd_mag   = dvd_neg ? -dividend_i : dividend_i;
   assign dvs_mag   = dvs_neg ? -divisor_i : divisor_i;
   assign quo_next  = {quo_q[WIDTH-2:0], q_bit};

   div32_seq_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_q),
      .dvd_bit  (quo_q[WIDTH-1]),
      .divisor  (dvsr_q),
      .rem_next (rem_next),
      .q_bit    (q_bit)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= DIV_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         DIV_IDLE, DIV_DONE: begin
            if (start_i) state_d = div_zero ? DIV_DONE : DIV_CALC;
            else         state_d = DIV_IDLE;
         end
         DIV_CALC: if (last_step) state_d = DIV_DONE;
         default:  state_d = DIV_IDLE;
      endcase
   end

   always_comb begin
      busy_o = (state_q == DIV_CALC);
      done_o = (state_q == DIV_DONE);
   end

   // Results are written only when entering DIV_DONE, so they hold across IDLE and the next CALC.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q         <= '0;
         rem_q         <= '0;
         quo_q         <= '0;
         dvsr_q        <= '0;
         quo_neg_q     <= 1'b0;
         rem_neg_q     <= 1'b0;
         quotient_o    <= '0;
         remainder_o   <= '0;
         div_by_zero_o <= 1'b0;
      end else if (accept) begin
         if (div_zero) begin
            quotient_o    <= '1;
            remainder_o   <= dividend_i;
            div_by_zero_o <= 1'b1;
         end else begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= dvd_mag;
            dvsr_q    <= dvs_mag;
            quo_neg_q <= dvd_neg ^ dvs_neg;
            rem_neg_q <= dvd_neg;
         end
      end else if (state_q == DIV_CALC) begin
         cnt_q <= cnt_q + DIV_CNT_W'(1);
         rem_q <= rem_next;
         quo_q <= quo_next;
         if (last_step) begin
            quotient_o    <= quo_neg_q ? -quo_next : quo_next;
            remainder_o   <= rem_neg_q ? -rem_next : rem_next;
            div_by_zero_o <= 1'b0;
         end
      end
   end

endmodule
